// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C EEPROM slave.
// Holds the FSM state encoding, the bus ACK/NACK levels and parameter checks.
// Pure declarations; no logic, no latency, no flow control.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    ADDR,
    ADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // True when the word-address width, memory depth and page size fit together
  function automatic bit params_legal(input int unsigned addr_bytes,
                                      input int unsigned mem_depth,
                                      input int unsigned page_size);
    bit ok;
    ok = (addr_bytes == 1) || (addr_bytes == 2);
    ok = ok && is_pow2(mem_depth) && (mem_depth >= 2);
    ok = ok && (mem_depth <= (32'd1 << (8 * addr_bytes)));
    ok = ok && is_pow2(page_size) && (page_size <= mem_depth);
    return ok;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for one bus line with rise/fall strobes on the synced value.
// Latency: 2 clk to sync_o; strobes are valid in the cycle sync_o changes.
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resynchronise the line and keep one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C EEPROM-style slave: device/word address decode, page-wrapped writes, sequential reads.
// Latency: SDA responses follow the bus SCL edge by about 3 clk (sync + output register).
// Backpressure: none; the slave never stretches SCL, so the master must honour min SCL times.
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'b1010101,
  parameter int unsigned ADDR_BYTES = 1,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned PAGE_SIZE  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oe,
  output logic busy,
  output logic wr_pulse
);

  localparam int unsigned   PW        = $clog2(MEM_DEPTH);
  localparam logic [PW-1:0] PAGE_MASK = PW'(PAGE_SIZE - 1);

  if (!params_legal(ADDR_BYTES, MEM_DEPTH, PAGE_SIZE)) begin : g_bad_params
    $error("i2c_eeprom_slave: illegal ADDR_BYTES/MEM_DEPTH/PAGE_SIZE combination");
  end

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(scl_in),
    .sync_o (scl_s),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(sda_in),
    .sync_o (sda_s),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    shreg_q;
  logic [PW-1:0] ptr_q;
  logic [7:0]    addr_hi_q;
  logic          addr_idx_q;
  logic          rw_q;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_pulse_q;
  logic          mem_we;
  logic [7:0]    mem_q [MEM_DEPTH];

  logic          start_det, stop_det;
  logic [7:0]    rx_byte;
  logic          byte_done;
  logic          dev_match;
  logic          addr_last;
  logic          rd_bit;
  logic [PW-1:0] ptr_load;
  logic [PW-1:0] ptr_page_next;

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;
  // The byte in flight including the bit arriving on this rising edge
  assign rx_byte   = {shreg_q, sda_s};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  assign dev_match = (rx_byte[7:1] == DEV_ADDR);
  assign addr_last = (addr_idx_q == 1'(ADDR_BYTES - 1));
  // Bits go out MSB first, so bit index is 7 - bit_cnt
  assign rd_bit    = mem_q[ptr_q][~bit_cnt_q];
  assign ptr_load  = (ADDR_BYTES == 2) ? PW'({addr_hi_q, rx_byte}) : PW'(rx_byte);
  assign ptr_page_next = (ptr_q & ~PAGE_MASK) | ((ptr_q + PW'(1)) & PAGE_MASK);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: bus conditions override everything; otherwise advance on SCL rising edges
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = DEV;
    end else begin
      case (state_q)
        DEV:       if (byte_done) state_d = dev_match ? DEV_ACK : IGNORE;
        DEV_ACK:   if (scl_rise) state_d = rw_q ? RDATA : ADDR;
        ADDR:      if (byte_done) state_d = ADDR_ACK;
        ADDR_ACK:  if (scl_rise) state_d = (addr_idx_q == 1'b0) ? WDATA : ADDR;
        WDATA:     if (byte_done) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_rise) state_d = WDATA;
        RDATA:     if (byte_done) state_d = RDATA_ACK;
        RDATA_ACK: if (scl_rise) state_d = (sda_s == I2C_ACK) ? RDATA : IGNORE;
        IDLE, IGNORE: state_d = state_q;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Outputs: SDA only moves on SCL falling edges; ack states pull low for one SCL low phase
  always_comb begin
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    mem_we   = 1'b0;
    if (stop_det || start_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        DEV: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (byte_done && dev_match) busy_d = 1'b1;
        end
        ADDR:      if (scl_fall) sda_oe_d = 1'b0;
        WDATA: begin
          if (scl_fall) sda_oe_d = 1'b0;
          mem_we = byte_done;
        end
        DEV_ACK, ADDR_ACK, WDATA_ACK: if (scl_fall) sda_oe_d = 1'b1;
        RDATA:     if (scl_fall) sda_oe_d = ~rd_bit;
        RDATA_ACK: if (scl_fall) sda_oe_d = 1'b0;
        default:   sda_oe_d = 1'b0;
      endcase
    end
  end

  // Datapath: bit counter, shift register, word-address capture and memory pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 7'd0;
      ptr_q      <= '0;
      addr_hi_q  <= 8'd0;
      addr_idx_q <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= mem_we;
      if (start_det || stop_det) begin
        bit_cnt_q  <= 3'd0;
        addr_idx_q <= 1'b0;
      end else begin
        // Counter wraps 7 -> 0 at byte end, so ack states need no explicit clear
        if (scl_rise && (state_q inside {DEV, ADDR, WDATA, RDATA})) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          shreg_q   <= rx_byte[6:0];
        end
        if (byte_done && (state_q == DEV)) rw_q <= rx_byte[0];
        if (byte_done && (state_q == ADDR)) begin
          if (addr_last) begin
            ptr_q      <= ptr_load;
            addr_idx_q <= 1'b0;
          end else begin
            addr_hi_q  <= rx_byte;
            addr_idx_q <= 1'b1;
          end
        end
        if (mem_we) ptr_q <= ptr_page_next;
        // Pointer moves past every byte delivered, so a later current-address read resumes after it
        if ((state_q == RDATA_ACK) && scl_rise) ptr_q <= ptr_q + PW'(1);
      end
    end
  end

  // Storage array; deliberately not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[ptr_q] <= rx_byte;
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged I2C master with open-drain SDA.
// Latency: master SCL half period is H clk cycles.
// Backpressure: none; all bus tasks run for fixed cycle counts.
module tb_i2c_eeprom_slave;
  import i2c_pkg::*;

  localparam int H = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, busy, wr_pulse;
  logic sda_line;

  assign sda_line = sda_m & ~sda_oe;

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  int oe_viol = 0;
  logic prev_oe = 1'b0;

  i2c_eeprom_slave dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_m),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  // Activity counters sampled away from the active edge
  always @(negedge clk) begin
    if (wr_pulse) wr_cnt++;
    if (sda_oe)   oe_cnt++;
    if (busy)     busy_cnt++;
  end

  // SDA drive may only change while bus SCL is low
  always @(posedge clk) begin
    if (!rst && (sda_oe !== prev_oe) && scl_m) oe_viol++;
    prev_oe = sda_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; idle(H/2);
    scl_m = 1'b1; idle(H/2);
    sda_m = 1'b0; idle(H/2);
    scl_m = 1'b0; idle(H/2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; idle(H/2);
    scl_m = 1'b1; idle(H/2);
    sda_m = 1'b1; idle(H);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    idle(H/2);
    scl_m = 1'b1; idle(H);
    scl_m = 1'b0; idle(H/2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    sda_m = 1'b1; idle(H/2);
    scl_m = 1'b1; idle(H/2);
    ack = sda_line; idle(H/2);
    scl_m = 1'b0; idle(H/2);
  endtask

  task automatic recv_byte(input logic m_ack, output logic [7:0] d);
    sda_m = 1'b1;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idle(H/2);
      scl_m = 1'b1; idle(H/2);
      d = {d[6:0], sda_line}; idle(H/2);
      scl_m = 1'b0;
    end
    idle(H/2);
    sda_m = m_ack; idle(H/2);
    scl_m = 1'b1;  idle(H);
    scl_m = 1'b0;  idle(H/2);
  endtask

  initial begin
    logic ack;
    logic [7:0] d;
    int wr0, oe0, busy0;

    // Reset state
    idle(5);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_ptr", 32'(dut.ptr_q), 32'h00);
    rst = 1'b0;
    idle(10);

    // Single byte write: 0x55 to 0xA5
    wr0 = wr_cnt;
    bus_start();
    send_byte(8'hAA, ack); chk("wr_dev_ack", 32'(ack), 32'd0);
    chk("wr_busy", 32'(busy), 32'd1);
    send_byte(8'hA5, ack); chk("wr_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h55, ack); chk("wr_data_ack", 32'(ack), 32'd0);
    bus_stop();
    chk("wr_mem_a5", 32'(dut.mem_q[8'hA5]), 32'h55);
    chk("wr_pulses", 32'(wr_cnt - wr0), 32'd1);
    chk("wr_busy_after_stop", 32'(busy), 32'd0);
    chk("wr_state_idle", 32'(dut.state_q), 32'(IDLE));

    // Random read of 0xA5 via repeated START, NACK ends it
    bus_start();
    send_byte(8'hAA, ack); chk("rr_dev_ack", 32'(ack), 32'd0);
    send_byte(8'hA5, ack); chk("rr_addr_ack", 32'(ack), 32'd0);
    bus_start();
    send_byte(8'hAB, ack); chk("rr_rdev_ack", 32'(ack), 32'd0);
    recv_byte(I2C_NACK, d); chk("rr_data", 32'(d), 32'h55);
    chk("rr_state_ignore", 32'(dut.state_q), 32'(IGNORE));
    chk("rr_busy_after_nack", 32'(busy), 32'd1);
    bus_stop();
    chk("rr_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("rr_busy_after_stop", 32'(busy), 32'd0);

    // Page write from 0x0F wraps to 0x00 within the 16-byte page
    wr0 = wr_cnt;
    bus_start();
    send_byte(8'hAA, ack);
    send_byte(8'h0F, ack);
    send_byte(8'h11, ack); chk("pw_ack1", 32'(ack), 32'd0);
    send_byte(8'h22, ack); chk("pw_ack2", 32'(ack), 32'd0);
    send_byte(8'h33, ack); chk("pw_ack3", 32'(ack), 32'd0);
    bus_stop();
    chk("pw_mem_0f", 32'(dut.mem_q[8'h0F]), 32'h11);
    chk("pw_mem_00", 32'(dut.mem_q[8'h00]), 32'h22);
    chk("pw_mem_01", 32'(dut.mem_q[8'h01]), 32'h33);
    chk("pw_pulses", 32'(wr_cnt - wr0), 32'd3);
    chk("pw_ptr", 32'(dut.ptr_q), 32'h02);

    // Sequential read across the top of memory: 0xFF then 0x00
    bus_start();
    send_byte(8'hAA, ack);
    send_byte(8'hFF, ack);
    send_byte(8'hC3, ack); chk("sr_prep_ack", 32'(ack), 32'd0);
    bus_stop();
    bus_start();
    send_byte(8'hAA, ack);
    send_byte(8'hFF, ack);
    bus_start();
    send_byte(8'hAB, ack);
    recv_byte(I2C_ACK, d);  chk("sr_byte_ff", 32'(d), 32'hC3);
    recv_byte(I2C_NACK, d); chk("sr_byte_00", 32'(d), 32'h22);
    chk("sr_ptr", 32'(dut.ptr_q), 32'h01);
    bus_stop();

    // Address mismatch: slave stays silent and idle
    wr0 = wr_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
    bus_start();
    send_byte(8'h50, ack); chk("mm_dev_nack", 32'(ack), 32'd1);
    send_byte(8'h0F, ack);
    send_byte(8'h99, ack);
    bus_stop();
    chk("mm_oe_never", 32'(oe_cnt - oe0), 32'd0);
    chk("mm_busy_never", 32'(busy_cnt - busy0), 32'd0);
    chk("mm_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("mm_mem_0f", 32'(dut.mem_q[8'h0F]), 32'h11);

    // STOP after 4 data bits abandons the byte
    wr0 = wr_cnt;
    bus_start();
    send_byte(8'hAA, ack);
    send_byte(8'h01, ack);
    for (int i = 0; i < 4; i++) put_bit(1'b1);
    bus_stop();
    chk("ab_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("ab_mem_01", 32'(dut.mem_q[8'h01]), 32'h33);
    chk("ab_state_idle", 32'(dut.state_q), 32'(IDLE));
    chk("ab_ptr", 32'(dut.ptr_q), 32'h01);

    // Reset while the slave drives a read bit (mem[0]=0x22, MSB 0 -> pulled low)
    bus_start();
    send_byte(8'hAA, ack);
    send_byte(8'h00, ack);
    bus_start();
    send_byte(8'hAB, ack);
    chk("rs_driving", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    idle(1);
    chk("rs_released", 32'(sda_oe), 32'd0);
    chk("rs_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    idle(4);
    oe0 = oe_cnt;
    send_byte(8'hAA, ack); chk("rs_ignored_ack", 32'(ack), 32'd1);
    chk("rs_ignored_oe", 32'(oe_cnt - oe0), 32'd0);
    bus_stop();
    bus_start();
    send_byte(8'hAA, ack);
    send_byte(8'h0F, ack);
    bus_start();
    send_byte(8'hAB, ack);
    recv_byte(I2C_NACK, d); chk("rs_mem_kept", 32'(d), 32'h11);
    bus_stop();

    chk("oe_only_scl_low", 32'(oe_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
